// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // 32-bit add that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with single-cycle flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full
);

    fetch_entry_t      mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_push;
    logic              do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy tracking; flush empties the queue in one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage, no reset needed since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests and
// buffers returned instructions for IF/ID. Redirects flush the stream.
// Define FETCH_PERF_EN to add saturating fetch/discard/starve counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        ready_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_discarded_o,
    output logic [31:0] perf_starve_o
`endif
);

    import fetch_pkg::*;

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned CNT1_W = CNT_W + 1;

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [31:0]       fetch_pc_q;
    logic [31:0]       fetch_pc_d;
    logic [31:0]       inflight_pc_q;
    logic [31:0]       inflight_pc_d;
    logic              req_c;
    logic              push;
    logic              pop;
    logic              space;
    logic [31:0]       redirect_pc;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT1_W-1:0] cnt_after;
    logic              fifo_empty;
    logic              fifo_full;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    assign redirect_pc      = redirect_pc_i & ~32'h0000_0003;
    assign pop              = !fifo_empty && ready_i;
    assign push             = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
    assign cnt_after        = {1'b0, fifo_count} + CNT1_W'(push) - CNT1_W'(pop);
    assign space            = (cnt_after < CNT1_W'(DEPTH));
    assign push_entry.pc    = inflight_pc_q;
    assign push_entry.instr = imem_rdata_i;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // FSM state, fetch PC and in-flight PC registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Next-state and request generation; redirect overrides the normal flow
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        req_c         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_full || pop) begin
                    req_c = 1'b1;
                    if (imem_gnt_i) begin
                        state_d       = WAIT;
                        fetch_pc_d    = fetch_pc_q + PC_STEP;
                        inflight_pc_d = fetch_pc_q;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                req_c = 1'b1;
                if (imem_gnt_i) begin
                    state_d       = WAIT;
                    fetch_pc_d    = fetch_pc_q + PC_STEP;
                    inflight_pc_d = fetch_pc_q;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = space ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (imem_rvalid_i) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect_i) begin
            fetch_pc_d = redirect_pc;
            case (state_q)
                IDLE, REQ:     state_d = (req_c && imem_gnt_i) ? DISCARD : REQ;
                WAIT, DISCARD: state_d = imem_rvalid_i ? REQ : DISCARD;
                default:       state_d = REQ;
            endcase
        end
    end

    // Request port and IF/ID-facing head view
    always_comb begin
        imem_req_o  = req_c && !reset;
        imem_addr_o = fetch_pc_q;
        valid_o     = !fifo_empty;
        instr_f     = fifo_empty ? NOP_INSTR : head.instr;
        pc_f        = fifo_empty ? 32'd0 : head.pc;
        pc_plus4_f  = fifo_empty ? 32'd0 : head.pc + PC_STEP;
    end

`ifdef FETCH_PERF_EN
    logic        drop;
    logic [31:0] flushed;

    assign drop    = imem_rvalid_i && ((state_q == DISCARD) || ((state_q == WAIT) && redirect_i));
    assign flushed = redirect_i ? (32'(fifo_count) - 32'(pop)) : 32'd0;

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_o   <= '0;
            perf_discarded_o <= '0;
            perf_starve_o    <= '0;
        end else begin
            perf_fetched_o   <= sat_add32(perf_fetched_o, 32'(push));
            perf_discarded_o <= sat_add32(perf_discarded_o, 32'(drop) + flushed);
            perf_starve_o    <= sat_add32(perf_starve_o, 32'(ready_i && fifo_empty));
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a req/gnt/rvalid memory model and
// a queue of expected IF/ID entries checked on every pop.
module tb_fetch_unit;

    import fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_discarded;
    logic [31:0] perf_starve;
`endif

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (2),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .ready_i       (ready),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .valid_o       (valid),
        .instr_f       (instr_f),
        .pc_f          (pc_f),
        .pc_plus4_f    (pc_plus4_f)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_o   (perf_fetched),
        .perf_discarded_o (perf_discarded),
        .perf_starve_o    (perf_starve)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           total;
    int           bad;
    fetch_entry_t exp_q[$];
    bit           ready_en;
    int           gnt_delay;
    int           rv_lat;
    bit           m_pend;
    logic [31:0]  m_addr;
    int           m_lat;
    int           m_wait;
    int           m_resp;
    logic         s_req;
    logic         s_valid;
    logic [31:0]  s_addr;
    logic [31:0]  s_instr;
    logic [31:0]  s_pc;
    logic [31:0]  s_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA5A5_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        exp_q.push_back(e);
    endtask

    // One clock: memory responds at negedge, outputs sampled, pops scored,
    // memory state advanced at posedge. Returns just after the posedge.
    task automatic step();
        fetch_entry_t e;
        ready = ready_en && (exp_q.size() != 0);
        @(negedge clk);
        imem_gnt    = imem_req && !m_pend && (m_wait >= gnt_delay);
        imem_rvalid = m_pend && (m_lat == 0);
        imem_rdata  = imem_rvalid ? mem_word(m_addr) : 32'hDEAD_BEEF;
        #1;
        s_req   = imem_req;
        s_valid = valid;
        s_addr  = imem_addr;
        s_instr = instr_f;
        s_pc    = pc_f;
        s_pc4   = pc_plus4_f;
        if (valid && ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pop_pc", pc_f, e.pc);
            check("pop_instr", instr_f, e.instr);
            check("pop_pc4", pc_plus4_f, e.pc + 32'd4);
        end
        @(posedge clk);
        if (reset) begin
            m_pend = 1'b0;
            m_lat  = 0;
            m_wait = 0;
            m_resp = 0;
        end else begin
            if (imem_rvalid) begin
                m_pend = 1'b0;
                m_resp++;
            end else if (m_pend) begin
                m_lat--;
            end
            if (s_req && imem_gnt) begin
                m_pend = 1'b1;
                m_addr = s_addr;
                m_lat  = rv_lat - 1;
                m_wait = 0;
            end else if (s_req) begin
                m_wait++;
            end else begin
                m_wait = 0;
            end
        end
        #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        redirect  = 1'b0;
        ready_en  = 1'b0;
        gnt_delay = 0;
        rv_lat    = 1;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        ready       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        m_pend      = 1'b0;
        m_addr      = 32'd0;
        m_lat       = 0;
        m_wait      = 0;
        m_resp      = 0;
        #1;

        // Test 1: reset values, then streaming with 1-cycle memory
        do_reset();
        check("rst_req", 32'(s_req), 32'd0);
        check("rst_addr", s_addr, 32'h0000_0000);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_instr", s_instr, 32'h0000_0013);
        check("rst_pc", s_pc, 32'd0);
        check("rst_pc4", s_pc4, 32'd0);
        ready_en = 1'b1;
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        step();
        check("t1_a_valid", 32'(s_valid), 32'd0);
        check("t1_a_req", 32'(s_req), 32'd1);
        check("t1_a_addr", s_addr, 32'h0);
        step();
        check("t1_b_valid", 32'(s_valid), 32'd0);
        step();
        check("t1_c_valid", 32'(s_valid), 32'd1);
        check("t1_c_pc", s_pc, 32'h0);
        drain("t1_drain", 20);

        // Test 2: stall fills the FIFO, requests stop, then drain in order
        do_reset();
        push_exp(32'h0);
        push_exp(32'h4);
        for (int i = 0; i < 10; i++) step();
        check("t2_full_req", 32'(s_req), 32'd0);
        check("t2_full_valid", 32'(s_valid), 32'd1);
        check("t2_full_pc", s_pc, 32'h0);
        ready_en = 1'b1;
        step();
        check("t2_resume_req", 32'(s_req), 32'd1);
        check("t2_resume_addr", s_addr, 32'h8);
        drain("t2_drain", 10);

        // Test 3: redirect in WAIT, stale response arrives in DISCARD
        do_reset();
        rv_lat   = 2;
        ready_en = 1'b1;
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h100);
        n = 0;
        while (!(m_pend && m_addr == 32'h8 && m_lat != 0) && n < 30) begin
            step();
            n++;
        end
        check("t3_reached_wait", 32'(m_pend && m_addr == 32'h8), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        step();
        check("t3_discard_valid", 32'(s_valid), 32'd0);
        check("t3_discard_req", 32'(s_req), 32'd0);
        step();
        check("t3_new_req", 32'(s_req), 32'd1);
        check("t3_new_addr", s_addr, 32'h100);
        drain("t3_drain", 20);

        // Test 4: redirect with rvalid in the same cycle, unaligned target
        do_reset();
        push_exp(32'h200);
        n = 0;
        while (!(m_pend && m_addr == 32'h4) && n < 30) begin
            step();
            n++;
        end
        check("t4_reached_wait", 32'(m_pend && m_addr == 32'h4), 32'd1);
        check("t4_pre_valid", 32'(s_valid), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        step();
        step();
        check("t4_flushed_valid", 32'(s_valid), 32'd0);
        check("t4_new_req", 32'(s_req), 32'd1);
        check("t4_new_addr", s_addr, 32'h200);
        ready_en = 1'b1;
        drain("t4_drain", 10);

        // Test 5: slow grant, redirect while the request is ungranted
        do_reset();
        gnt_delay = 3;
        ready_en  = 1'b1;
        push_exp(32'h300);
        step();
        check("t5_a_req", 32'(s_req), 32'd1);
        check("t5_a_addr", s_addr, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        check("t5_b_addr", s_addr, 32'h0);
        step();
        check("t5_retarget_req", 32'(s_req), 32'd1);
        check("t5_retarget_addr", s_addr, 32'h300);
        drain("t5_drain", 20);
        check("t5_responses", 32'(m_resp), 32'd1);

        // Test 6: reset asserted while a response is outstanding
        do_reset();
        rv_lat = 2;
        n = 0;
        while (!(m_pend && m_addr == 32'h4) && n < 30) begin
            step();
            n++;
        end
        check("t6_reached_wait", 32'(m_pend && m_addr == 32'h4), 32'd1);
        check("t6_pre_valid", 32'(s_valid), 32'd1);
        reset = 1'b1;
        step();
        check("t6_rst_req", 32'(s_req), 32'd0);
        check("t6_rst_valid", 32'(s_valid), 32'd0);
        check("t6_rst_addr", s_addr, 32'h0);
        check("t6_rst_instr", s_instr, 32'h0000_0013);
        check("t6_rst_pc4", s_pc4, 32'd0);
        reset    = 1'b0;
        ready_en = 1'b1;
        push_exp(32'h0);
        push_exp(32'h4);
        step();
        check("t6_refetch_req", 32'(s_req), 32'd1);
        check("t6_refetch_addr", s_addr, 32'h0);
        drain("t6_drain", 20);

        // Test 7: redirect during a granted IDLE issue, PC wraps past top
        do_reset();
        ready_en = 1'b1;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        step();
        check("t7_discard_req", 32'(s_req), 32'd0);
        step();
        check("t7_wrap_addr", s_addr, 32'hFFFF_FFFC);
        drain("t7_drain", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues requests on a req/gnt/rvalid instruction-memory port, with at most one access outstanding.
- Buffers returned instructions in a small FIFO and presents {instr_f, pc_f, pc_plus4_f} to IF/ID.
- A redirect from Execute (taken branch/jump) flushes the fetch stream.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 2, instruction FIFO entries; power of two, 2..8.
NOP_INSTR, 32'h0000_0013, instruction driven on instr_f while the FIFO is empty.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
redirect_i  in  1  taken branch/jump from Execute.
redirect_pc_i  in  32  redirect target.
ready_i  in  1  IF/ID accepts this cycle (IF/ID enable, i.e. not stalled).
imem_req_o  out  1  memory request.
imem_addr_o  out  32  request address, word-aligned.
imem_gnt_i  in  1  request accepted this cycle.
imem_rvalid_i  in  1  read data valid; earliest one cycle after gnt.
imem_rdata_i  in  32  read data.
valid_o  out  1  FIFO head valid.
instr_f  out  32  head instruction, or NOP_INSTR when empty.
pc_f  out  32  head PC, or 0 when empty.
pc_plus4_f  out  32  pc_f + 4, or 0 when empty.

Behaviour:
- Reset values:
  - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, valid_o=0, instr_f=NOP_INSTR, pc_f=0, pc_plus4_f=0.
  - Internal: fetch PC = RESET_PC, FIFO empty, FSM in IDLE.
- FSM states and transitions:
  - IDLE: no access in flight. If space exists (count < DEPTH), drive imem_req_o=1 with imem_addr_o = fetch PC; move to REQ.
  - REQ: hold req.
    - On gnt: move to WAIT; fetch PC += 4; record the issued PC in the in-flight register.
    - imem_addr_o may change while ungranted; imem tolerates this.
  - WAIT: wait for rvalid.
    - On rvalid: push {recorded PC, rdata} to the FIFO.
    - If space remains after this cycle's push/pop, move directly to REQ, so back-to-back issue is legal; otherwise go to IDLE.
  - DISCARD: entered on redirect while in WAIT. On rvalid, drop the data and move to REQ at the new PC.
- Space check: count_next < DEPTH, counting the in-flight slot. A response therefore always has room; overflow is impossible by construction.
- Pop: valid_o && ready_i removes the head. Push and pop in the same cycle are both performed and count is unchanged.
- Outputs are combinational from the FIFO head, so zero-cycle latency from head to IF/ID. First instruction appears at valid_o no earlier than 2 cycles after reset release (gnt cycle, then rvalid cycle).
- Redirect (highest priority), in the same cycle:
  - FIFO flushed, so valid_o=0 from the next cycle.
  - Fetch PC <= {redirect_pc_i[31:2], 2'b00}.
  - REQ ungranted: retarget to the new PC next cycle.
  - REQ granted this same cycle, or WAIT: go to DISCARD.
  - IDLE: go to REQ.
  - DISCARD: stay in DISCARD.
  - Pop in the redirect cycle is still honoured, since IF/ID captures it; IF/ID clear handles squash.
- Redirect and rvalid in the same cycle: the response is discarded and the FSM moves to REQ.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Reset mid-operation: immediately returns to reset values. Any in-flight response is ignored; imem shares the same reset.

Optional Feature:
- FETCH_PERF_EN defined adds three 32-bit saturating counters, readable as outputs:
  - perf_fetched_o: FIFO pushes.
  - perf_discarded_o: DISCARD drops plus flushed entries.
  - perf_starve_o: cycles with ready_i=1 and valid_o=0.
- Counters clear on reset.
- Undefined: the ports and logic are absent.

Decomposition:
- Package fetch_pkg: FSM state enum (IDLE, REQ, WAIT, DISCARD), fetch-entry struct {pc[31:0], instr[31:0]}, constants NOP_INSTR and PC_STEP=4.
- Sub-module fetch_fifo: parameterized synchronous FIFO of fetch entries with flush, push, pop, count, empty and full.

Test Plan:
1. Reset, 1-cycle gnt/rvalid memory, ready_i=1 -> pc_f sequence 0x0, 0x4, 0x8 with instr_f matching memory; valid_o first high 2 cycles after reset release.
2. ready_i=0 for 10 cycles -> FIFO fills to DEPTH=2; imem_req_o low while full; after release, entries 0x0 and 0x4 drain in order with no loss.
3. Redirect to 0x100 while in WAIT; rvalid of the stale 0x8 arrives next cycle -> stale data never appears; next valid pc_f=0x100.
4. Redirect and rvalid in the same cycle, plus redirect_pc_i=0x203 -> response dropped; next imem_addr_o=0x200.
5. gnt delayed 3 cycles, redirect during ungranted REQ -> imem_addr_o switches to the new target; exactly one response is consumed.
6. Assert reset while in WAIT -> outputs return to reset values next edge; refetch starts at RESET_PC.
